serial_operand_adder: RTL and testbench

//  Byte-serial multi-word adder wrapped around the team's 8-bit prefix adder (module `adder`).
//  - Accepts an operand pair as a stream of byte beats, least-significant byte first.
//  - Chains the carry between beats in a register and emits one registered sum byte per beat.
//  - Sits between the operand fetch stream and the result writeback stream, so arbitrary-length adds reuse one 8-bit core.

---
 rtl/serial_operand_adder.sv | 207 ++++++++++++++++++++
 tb/tb_serial_operand_adder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_operand_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_operand_adder (with helper module adder)
// Purpose  : Byte-serial multi-word adder. Operand pairs arrive as byte beats,
//            least-significant byte first. The carry is chained between beats
//            in a register, so adds of any length reuse one 8-bit prefix adder.
//            One registered sum byte is produced per accepted beat.
// Ports    : clk, rst                     - clock, synchronous active-high reset
//            in_valid/in_ready            - input beat handshake
//            in_a, in_b, in_cin           - operand bytes, carry-in (first beat)
//            in_first, in_last            - framing of the operation
//            out_valid/out_ready          - result beat handshake
//            out_sum, out_last            - sum byte and final-beat marker
//            out_cout, out_ovf            - final carry / signed overflow
//            out_len                      - beats so far, saturating
//            err_proto                    - one-cycle framing-error pulse
// Revision : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// adder : 8-bit Kogge-Stone prefix adder with carry-in.
// ----------------------------------------------------------------------------
module adder (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] w_p0;
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [7:0] w_g_nxt;
    logic [7:0] w_p_nxt;
    logic [8:0] w_c;

    always_comb begin
        w_p0    = a ^ b;
        w_g     = a & b;
        w_p     = w_p0;
        w_g_nxt = w_g;
        w_p_nxt = w_p;
        // Three prefix levels with spans 1, 2, 4 combine (G,P) over [i:0].
        for (int lvl = 0; lvl < 3; lvl++) begin
            w_g_nxt = w_g;
            w_p_nxt = w_p;
            for (int i = 0; i < 8; i++) begin
                if (i >= (1 << lvl)) begin
                    w_g_nxt[i] = w_g[i] | (w_p[i] & w_g[i - (1 << lvl)]);
                    w_p_nxt[i] = w_p[i] & w_p[i - (1 << lvl)];
                end
            end
            w_g = w_g_nxt;
            w_p = w_p_nxt;
        end
        // Carry-in enters as a generate below bit 0 of every group.
        w_c[0] = cin;
        for (int i = 0; i < 8; i++) begin
            w_c[i + 1] = w_g[i] | (w_p[i] & cin);
        end
        sum  = w_p0 ^ w_c[7:0];
        cout = w_c[8];
    end

endmodule

// ----------------------------------------------------------------------------
// serial_operand_adder : framing FSM, carry chain and output register.
// ----------------------------------------------------------------------------
module serial_operand_adder #(
    parameter int CNT_W      = 8,
    parameter bit SIGNED_OVF = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_cin,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_len,
    output logic             err_proto
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    state_t           r_state;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_cin;
    logic [7:0]       w_sum;
    logic             w_cout;
    logic             w_ovf;
    logic [CNT_W-1:0] w_count_inc;

    // Single output register: a new beat may enter whenever the register is
    // empty or being drained on this same edge.
    assign in_ready = !rst && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // A first beat always starts from the external carry-in, even when it
    // interrupts an open operation.
    assign w_cin = in_first ? in_cin : r_carry;

    assign w_count_inc = (r_count == c_cnt_max) ? r_count : r_count + c_cnt_one;

    adder u_adder (
        .a    (in_a),
        .b    (in_b),
        .cin  (w_cin),
        .sum  (w_sum),
        .cout (w_cout)
    );

    generate
        if (SIGNED_OVF) begin : g_ovf_on
            assign w_ovf = (in_a[7] == in_b[7]) && (w_sum[7] != in_a[7]);
        end else begin : g_ovf_off
            assign w_ovf = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_carry   <= 1'b0;
            r_count   <= '0;
            out_valid <= 1'b0;
            out_sum   <= 8'h00;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_len   <= '0;
            err_proto <= 1'b0;
        end else begin
            err_proto <= 1'b0;
            if (w_accept) begin
                if (in_first) begin
                    // A first beat inside an open operation abandons it.
                    err_proto <= (r_state == ST_BUSY);
                    out_valid <= 1'b1;
                    out_sum   <= w_sum;
                    out_len   <= c_cnt_one;
                    if (in_last) begin
                        out_last <= 1'b1;
                        out_cout <= w_cout;
                        out_ovf  <= w_ovf;
                        r_carry  <= 1'b0;
                        r_count  <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        out_last <= 1'b0;
                        out_cout <= 1'b0;
                        out_ovf  <= 1'b0;
                        r_carry  <= w_cout;
                        r_count  <= c_cnt_one;
                        r_state  <= ST_BUSY;
                    end
                end else if (r_state == ST_BUSY) begin
                    out_valid <= 1'b1;
                    out_sum   <= w_sum;
                    out_len   <= w_count_inc;
                    if (in_last) begin
                        out_last <= 1'b1;
                        out_cout <= w_cout;
                        out_ovf  <= w_ovf;
                        r_carry  <= 1'b0;
                        r_count  <= '0;
                        r_state  <= ST_IDLE;
                    end else begin
                        out_last <= 1'b0;
                        out_cout <= 1'b0;
                        out_ovf  <= 1'b0;
                        r_carry  <= w_cout;
                        r_count  <= w_count_inc;
                    end
                end else begin
                    // Orphan continuation beat: swallow it and flag it.
                    err_proto <= 1'b1;
                    out_valid <= 1'b0;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_operand_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_operand_adder
// Purpose  : Directed self-checking bench for serial_operand_adder. A second
//            instance (SIGNED_OVF=0, CNT_W=2) shares the input stimulus to
//            cover the overflow-disabled build and out_len saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_operand_adder;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_cin;
    logic       in_first;
    logic       in_last;
    logic       out_ready;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic       out_ovf;
    logic [7:0] out_len;
    logic       err_proto;

    logic       in_ready2;
    logic       out_valid2;
    logic [7:0] out_sum2;
    logic       out_last2;
    logic       out_cout2;
    logic       out_ovf2;
    logic [1:0] out_len2;
    logic       err_proto2;

    int n_vec;
    int n_miss;

    serial_operand_adder #(.CNT_W(8), .SIGNED_OVF(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_len   (out_len),
        .err_proto (err_proto)
    );

    serial_operand_adder #(.CNT_W(2), .SIGNED_OVF(1'b0)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_sum   (out_sum2),
        .out_last  (out_last2),
        .out_cout  (out_cout2),
        .out_ovf   (out_ovf2),
        .out_len   (out_len2),
        .err_proto (err_proto2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic first, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_first = first;
        in_last  = last;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one result beat of the main instance.
    task automatic chk_beat(input string tag, input logic [7:0] sum, input logic last,
                            input logic cout, input logic ovf, input logic [7:0] len);
        chk({tag, ".valid"}, {15'd0, out_valid}, 16'd1);
        chk({tag, ".sum"},   {8'd0, out_sum},    {8'd0, sum});
        chk({tag, ".last"},  {15'd0, out_last},  {15'd0, last});
        chk({tag, ".cout"},  {15'd0, out_cout},  {15'd0, cout});
        chk({tag, ".ovf"},   {15'd0, out_ovf},   {15'd0, ovf});
        chk({tag, ".len"},   {8'd0, out_len},    {8'd0, len});
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_cin    = 1'b0;
        idle();

        // Reset state
        step();
        step();
        chk("rst.in_ready",  {15'd0, in_ready},  16'd0);
        chk("rst.out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst.err",       {15'd0, err_proto}, 16'd0);
        chk("rst.sum",       {8'd0, out_sum},    16'd0);
        chk("rst.len",       {8'd0, out_len},    16'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", {15'd0, in_ready}, 16'd1);

        // 1: single-beat FF+01
        drive(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
        step();
        chk_beat("t1", 8'h00, 1'b1, 1'b1, 1'b0, 8'd1);
        idle();
        step();
        chk("t1.drain", {15'd0, out_valid}, 16'd0);

        // 2: 0x01FF + 0x0001 = 0x0200
        drive(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        step();
        chk_beat("t2a", 8'h00, 1'b0, 1'b0, 1'b0, 8'd1);
        drive(8'h01, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        chk_beat("t2b", 8'h02, 1'b1, 1'b0, 1'b0, 8'd2);
        idle();
        step();

        // 3: 7F+01 signed overflow; disabled in the second instance
        drive(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
        step();
        chk_beat("t3", 8'h80, 1'b1, 1'b0, 1'b1, 8'd1);
        chk("t3.nov_ovf", {15'd0, out_ovf2}, 16'd0);
        chk("t3.nov_sum", {8'd0, out_sum2},  16'h0080);
        idle();
        step();

        // 4: back-pressure for 3 cycles
        drive(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
        step();
        chk_beat("t4a", 8'h30, 1'b0, 1'b0, 1'b0, 8'd1);
        out_ready = 1'b0;
        drive(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        #1;
        chk("t4.in_ready_low", {15'd0, in_ready}, 16'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_beat("t4.hold", 8'h30, 1'b0, 1'b0, 1'b0, 8'd1);
            chk("t4.hold_ready", {15'd0, in_ready}, 16'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("t4.in_ready_high", {15'd0, in_ready}, 16'd1);
        step();
        chk_beat("t4b", 8'h03, 1'b0, 1'b0, 1'b0, 8'd2);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        chk_beat("t4c", 8'h00, 1'b1, 1'b0, 1'b0, 8'd3);
        idle();
        step();
        chk("t4.drain", {15'd0, out_valid}, 16'd0);

        // 5a: continuation beat while idle
        drive(8'h55, 8'hAA, 1'b0, 1'b0, 1'b1);
        step();
        chk("t5a.err",   {15'd0, err_proto}, 16'd1);
        chk("t5a.valid", {15'd0, out_valid}, 16'd0);
        idle();
        step();
        chk("t5a.err_clr", {15'd0, err_proto}, 16'd0);

        // 5b: first beat while busy restarts with in_cin
        drive(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
        step();
        chk_beat("t5b.open", 8'h02, 1'b0, 1'b0, 1'b0, 8'd1);
        drive(8'h03, 8'h04, 1'b1, 1'b1, 1'b0);
        step();
        chk("t5b.err", {15'd0, err_proto}, 16'd1);
        chk_beat("t5b.restart", 8'h08, 1'b0, 1'b0, 1'b0, 8'd1);
        drive(8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        step();
        chk("t5b.err_clr", {15'd0, err_proto}, 16'd0);
        chk_beat("t5b.close", 8'h00, 1'b1, 1'b0, 1'b0, 8'd2);
        idle();
        step();

        // 6: reset while busy
        drive(8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
        step();
        chk_beat("t6.open", 8'hFE, 1'b0, 1'b0, 1'b0, 8'd1);
        idle();
        rst = 1'b1;
        step();
        chk("t6.rst_valid", {15'd0, out_valid}, 16'd0);
        rst = 1'b0;
        drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
        step();
        chk("t6.err", {15'd0, err_proto}, 16'd0);
        chk_beat("t6.new", 8'h01, 1'b1, 1'b0, 1'b0, 8'd1);
        idle();
        step();

        // 7: five-beat op; 2-bit counter saturates at 3
        // 0x0000000001 + 0x00000000FF = 0x0000000100
        for (int k = 0; k < 5; k++) begin
            if (k == 0) drive(8'h01, 8'hFF, 1'b0, 1'b1, 1'b0);
            else        drive(8'h00, 8'h00, 1'b0, 1'b0, (k == 4));
            step();
            chk("t7.len",     {8'd0, out_len},   16'(k + 1));
            chk("t7.sat_len", {14'd0, out_len2}, (k < 3) ? 16'(k + 1) : 16'd3);
            chk("t7.sum",     {8'd0, out_sum},   (k == 1) ? 16'h0001 : 16'h0000);
        end
        chk("t7.last", {15'd0, out_last}, 16'd1);
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: got stalled run, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
